prism_bus_master: RTL and testbench

PRISM_BUS_MASTER -- requirements
Module: prism_bus_master

---
 rtl/prism_bus_pkg.sv | 26 ++
 rtl/prism_bus_master.sv | 157 +++++++++++++++
 tb/tb_prism_bus_master.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/prism_bus_pkg.sv
// Shared definitions for the prism bus master: FSM states, access-size codes
// and the read-data mask used to zero-extend narrow reads.
package prism_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_READ  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    localparam logic [1:0] SZ_8    = 2'b00;
    localparam logic [1:0] SZ_16   = 2'b01;
    localparam logic [1:0] SZ_32   = 2'b10;
    localparam logic [1:0] SZ_IDLE = 2'b11;

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_8:    size_mask = 32'h0000_00FF;
            SZ_16:   size_mask = 32'h0000_FFFF;
            SZ_32:   size_mask = 32'hFFFF_FFFF;
            default: size_mask = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/prism_bus_master.sv
// Single-outstanding command-to-peripheral bus master with a registered response.
// Build macro PRISM_BUS_TIMEOUT_EN adds a read timeout of TIMEOUT_CYCLES strobe cycles.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | cmd_ready high, strobes idle, bus outputs hold
// ST_WRITE | write strobe active for exactly one cycle
// ST_READ  | read strobe held until bus_ready (or timeout)
// ST_RESP  | response held stable until rsp_ready
module prism_bus_master
    import prism_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [5:0]  bus_address,
    output logic [31:0] bus_wdata,
    output logic [1:0]  bus_write_n,
    output logic [1:0]  bus_read_n,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        busy
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_timeout_range
        $error("prism_bus_master: TIMEOUT_CYCLES must be in 1..255");
    end

    state_e      state_q, state_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

`ifdef PRISM_BUS_TIMEOUT_EN
    // Down-counter loaded with TIMEOUT_CYCLES-1 so terminal count falls on the last allowed strobe cycle.
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
`ifdef PRISM_BUS_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    size_d  = cmd_size;
                    if (cmd_size == SZ_IDLE) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rdata_d     = '0;
                        err_d       = 1'b1;
                    end else if (cmd_write) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
`ifdef PRISM_BUS_TIMEOUT_EN
                        tmo_d   = TMO_LOAD;
`endif
                    end
                end
            end
            ST_WRITE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rdata_d     = '0;
                err_d       = 1'b0;
            end
            ST_READ: begin
                if (bus_ready) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rdata_d     = bus_rdata & size_mask(size_q);
                    err_d       = 1'b0;
                end
`ifdef PRISM_BUS_TIMEOUT_EN
                else if (tmo_q == '0) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rdata_d     = '0;
                    err_d       = 1'b1;
                end else begin
                    tmo_d = tmo_q - 8'd1;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= SZ_IDLE;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
`ifdef PRISM_BUS_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
`ifdef PRISM_BUS_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    // Strobes decode only registered state, so reset releases them asynchronously.
    assign bus_write_n = (state_q == ST_WRITE) ? size_q : SZ_IDLE;
    assign bus_read_n  = (state_q == ST_READ)  ? size_q : SZ_IDLE;
    assign bus_address = addr_q;
    assign bus_wdata   = wdata_q;
    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;

endmodule

// File: tb/tb_prism_bus_master.sv
// Scoreboard bench for prism_bus_master: expected responses are queued at command
// acceptance and compared at the response handshake.
module tb_prism_bus_master;

`ifdef PRISM_BUS_TIMEOUT_EN
    localparam int TMO    = 4;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 16;
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_size = 2'b00;
    logic [5:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [5:0]  bus_address;
    logic [31:0] bus_wdata;
    logic [1:0]  bus_write_n;
    logic [1:0]  bus_read_n;
    logic [31:0] bus_rdata = '0;
    logic        bus_ready = 1'b0;
    logic        busy;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    prism_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_size    (cmd_size),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .bus_address (bus_address),
        .bus_wdata   (bus_wdata),
        .bus_write_n (bus_write_n),
        .bus_read_n  (bus_read_n),
        .bus_rdata   (bus_rdata),
        .bus_ready   (bus_ready),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] model_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 32'h0000_00FF;
            2'b01:   return 32'h0000_FFFF;
            2'b10:   return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    // Full transaction starting in an IDLE cycle (inputs driven 1 time unit after a rising edge).
    // rdy_dly = strobe cycles with bus_ready low before it rises; hold = cycles rsp_ready stays low.
    task automatic run_cmd(input logic wr, input logic [1:0] sz, input logic [5:0] addr,
                           input logic [31:0] wd, input int rdy_dly, input logic [31:0] bus_val,
                           input int hold);
        int   exp_len;
        int   strobe;
        rsp_t exp;
        rsp_t got;

        if (sz == 2'b11)                      exp_len = 0;
        else if (wr)                          exp_len = 1;
        else if (TMO_EN && (rdy_dly >= TMO))  exp_len = TMO;
        else                                  exp_len = rdy_dly + 1;

        if (sz == 2'b11)       exp = '{rdata: 32'h0, err: 1'b1};
        else if (wr)           exp = '{rdata: 32'h0, err: 1'b0};
        else if (TMO_EN && (rdy_dly >= TMO))
                               exp = '{rdata: 32'h0, err: 1'b1};
        else                   exp = '{rdata: bus_val & model_mask(sz), err: 1'b0};

        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_size  = sz;
        cmd_addr  = addr;
        cmd_wdata = wd;
        bus_rdata = bus_val;
        bus_ready = 1'b0;
        @(posedge clk);
        sb_q.push_back(exp);
        #1;
        // Scramble command inputs to show bus outputs come from registered copies.
        cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_size  = ~sz;
        cmd_addr  = ~addr;
        cmd_wdata = ~wd;

        strobe = 0;
        for (int k = 0; k < 300; k++) begin
            if ((bus_write_n == 2'b11) && (bus_read_n == 2'b11)) break;
            strobe++;
            chk("strobe_exclusive", 32'((bus_write_n != 2'b11) && (bus_read_n != 2'b11)), 32'd0);
            chk("strobe_code", 32'(wr ? bus_write_n : bus_read_n), 32'(sz));
            chk("bus_address", 32'(bus_address), 32'(addr));
            chk("bus_wdata", bus_wdata, wd);
            chk("rsp_valid_in_strobe", 32'(rsp_valid), 32'd0);
            chk("busy_in_strobe", 32'(busy), 32'd1);
            bus_ready = (strobe > rdy_dly);
            @(posedge clk); #1;
        end
        bus_ready = 1'b0;
        chk("strobe_len", 32'(strobe), 32'(exp_len));

        chk("rsp_valid_rise", 32'(rsp_valid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_rsp_rdata", rsp_rdata, exp.rdata);
            chk("hold_rsp_err", 32'(rsp_err), 32'(exp.err));
            chk("hold_strobes", 32'({bus_write_n, bus_read_n}), 32'hF);
            @(posedge clk); #1;
        end

        rsp_ready = 1'b1;
        if (rsp_valid && (sb_q.size() > 0)) begin
            got = sb_q.pop_front();
            chk("rsp_rdata", rsp_rdata, got.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(got.err));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_addr_hold", 32'(bus_address), 32'(addr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_bus_address", 32'(bus_address), 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_write_n", 32'(bus_write_n), 32'h3);
        chk("rst_bus_read_n", 32'(bus_read_n), 32'h3);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_cmd(1'b1, 2'b10, 6'h28, 32'hA000_1234, 0, 32'h0, 0);
        run_cmd(1'b0, 2'b00, 6'h18, 32'h0, 0, 32'hDEAD_BEEF, 0);
        run_cmd(1'b0, 2'b01, 6'h04, 32'h0, 5, 32'h1234_5678, 0);
        run_cmd(1'b1, 2'b11, 6'h3F, 32'h5555_AAAA, 0, 32'h0, 3);
        run_cmd(1'b1, 2'b00, 6'h01, 32'hFFFF_FF81, 0, 32'h0, 1);
        run_cmd(1'b1, 2'b01, 6'h22, 32'h0BAD_CAFE, 0, 32'h0, 0);
        run_cmd(1'b0, 2'b10, 6'h2A, 32'h0, 2, 32'h8765_4321, 2);
        run_cmd(1'b0, 2'b11, 6'h10, 32'h0, 0, 32'hFFFF_FFFF, 0);

        for (int i = 0; i < 24; i++) begin
            run_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 6'($urandom),
                    $urandom, $urandom_range(0, 6), $urandom, $urandom_range(0, 2));
        end

        // Reset in the middle of a stalled read: no response, strobes released at once.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'b10; cmd_addr = 6'h15;
        bus_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("pre_rst_read_n", 32'(bus_read_n), 32'h2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_read_n", 32'(bus_read_n), 32'h3);
        chk("async_rst_write_n", 32'(bus_write_n), 32'h3);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("async_rst_bus_address", 32'(bus_address), 32'h0);
        @(posedge clk); #1;
        chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_cmd(1'b0, 2'b01, 6'h33, 32'h0, 1, 32'hCAFE_F00D, 0);
        run_cmd(1'b1, 2'b10, 6'h07, 32'h1357_9BDF, 0, 32'h0, 0);

`ifdef PRISM_BUS_TIMEOUT_EN
        run_cmd(1'b0, 2'b10, 6'h0C, 32'h0, 1000, 32'hFFFF_FFFF, 0);
        run_cmd(1'b0, 2'b00, 6'h0D, 32'h0, TMO - 1, 32'h0000_00A5, 1);
        run_cmd(1'b0, 2'b01, 6'h0E, 32'h0, TMO, 32'h0000_BEEF, 0);
`endif

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
